// File: rtl/baud_pkg.sv
// baud_pkg -- shared constants for the fractional baud generator.
//   Standard divisors assume a 100 MHz clock and 16x oversampling.
//   Each rate is given as integer cycles per oversample tick plus a
//   fractional part in 1/16 units (FRAC_W = 4).
package baud_pkg;

    localparam int CLK_HZ      = 100_000_000;
    localparam int OVS_DEFAULT = 16;

    // 100e6 / (9600*16)   = 651.04 -> 651 + 0/16
    localparam int DIV_9600    = 651;
    localparam int FRAC_9600   = 0;
    // 100e6 / (19200*16)  = 325.52 -> 325 + 8/16
    localparam int DIV_19200   = 325;
    localparam int FRAC_19200  = 8;
    // 100e6 / (115200*16) = 54.25  -> 54 + 4/16
    localparam int DIV_115200  = 54;
    localparam int FRAC_115200 = 4;

    localparam int BAUD_DEFAULT_DIV = DIV_9600;

endpackage

// File: rtl/baud_frac_div.sv
// baud_frac_div -- oversample period divider with optional fractional carry.
//   clk, rst      : clock, synchronous active-high reset
//   en            : run enable; when low the counter, accumulator and carry
//                   are held at 0 and no tick is produced
//   div, frac     : active divisor (0 is treated as 1) and fraction
//   wrap          : combinational terminal count (last cycle of a period)
//   ovs_tick      : registered pulse, asserted as the counter wraps
// Macro BAUD_GEN_FRAC_FRAC_EN enables the fractional accumulator; without
// it frac is ignored and every period is exactly the integer divisor.
module baud_frac_div #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  div,
    input  logic [FRAC_W-1:0] frac,
    output logic              wrap,
    output logic              ovs_tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;
    logic [DIV_W:0]   period;
    logic             carry;

    assign div_eff = (div == '0) ? DIV_W'(1) : div;
    // One bit wider so a full-scale divisor plus carry cannot overflow.
    assign period  = {1'b0, div_eff} + {{DIV_W{1'b0}}, carry};
    assign wrap    = en && ({1'b0, cnt} == period - (DIV_W+1)'(1));

`ifdef BAUD_GEN_FRAC_FRAC_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac};

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            acc   <= '0;
            carry <= 1'b0;
        end else if (wrap) begin
            // Overflow stretches the following period by one cycle.
            acc   <= acc_sum[FRAC_W-1:0];
            carry <= acc_sum[FRAC_W];
        end
    end
`else
    logic unused_frac;
    assign unused_frac = ^frac;
    assign carry       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt      <= '0;
            ovs_tick <= 1'b0;
        end else begin
            ovs_tick <= wrap;
            cnt      <= wrap ? '0 : cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac -- fractional baud rate generator.
//   clk, rst             : clock, synchronous active-high reset
//   en                   : run enable (low: everything held at 0)
//   cfg_valid/cfg_ready  : divisor handshake; one divisor may be pending
//   cfg_div, cfg_frac    : integer cycles per oversample tick, fraction /2^FRAC_W
//   ovs_tick             : 1-cycle pulse at OVS x baud
//   baud_tick            : 1-cycle pulse on every OVS-th ovs_tick
//   bclk                 : 50% duty square wave at the baud rate
// Macro BAUD_GEN_FRAC_FRAC_EN enables fractional division; without it
// cfg_frac is accepted on the port but ignored.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int DIV_W       = 16,
    parameter int FRAC_W      = 4,
    parameter int OVS         = OVS_DEFAULT,
    parameter int DEFAULT_DIV = BAUD_DEFAULT_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [FRAC_W-1:0] cfg_frac,
    output logic              ovs_tick,
    output logic              baud_tick,
    output logic              bclk
);

    localparam int OCW = (OVS > 2) ? $clog2(OVS) : 1;
    localparam logic [OCW-1:0] OCNT_LAST = OCW'(OVS - 1);
    localparam logic [OCW-1:0] OCNT_HALF = OCW'(OVS / 2 - 1);

    logic [DIV_W-1:0]  act_div;
    logic [DIV_W-1:0]  pend_div;
    logic [FRAC_W-1:0] act_frac;
    logic              pend_vld;
    logic [OCW-1:0]    ocnt;
    logic              wrap;
    logic              xfer;
    logic              apply;

    assign xfer  = cfg_valid && cfg_ready;
    // Swap divisors only at a period boundary (or immediately when idle)
    // so the running period is never truncated.
    assign apply = pend_vld && (wrap || !en);

    baud_frac_div #(
        .DIV_W  (DIV_W),
        .FRAC_W (FRAC_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div      (act_div),
        .frac     (act_frac),
        .wrap     (wrap),
        .ovs_tick (ovs_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_div  <= '0;
            act_div   <= DIV_W'(DEFAULT_DIV);
            cfg_ready <= 1'b1;
        end else begin
            if (xfer) begin
                pend_vld <= 1'b1;
                pend_div <= cfg_div;
            end else if (apply) begin
                pend_vld <= 1'b0;
                act_div  <= pend_div;
            end
            // Ready drops right after a transfer and comes back one cycle
            // after the pending divisor has been applied.
            cfg_ready <= xfer ? 1'b0 : !pend_vld;
        end
    end

`ifdef BAUD_GEN_FRAC_FRAC_EN
    logic [FRAC_W-1:0] pend_frac;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_frac <= '0;
            act_frac  <= '0;
        end else if (xfer) begin
            pend_frac <= cfg_frac;
        end else if (apply) begin
            act_frac  <= pend_frac;
        end
    end
`else
    logic unused_cfg_frac;
    assign unused_cfg_frac = ^cfg_frac;
    assign act_frac        = '0;
`endif

    // Oversample counter; OVS is a power of two so it wraps naturally.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            ocnt      <= '0;
            baud_tick <= 1'b0;
            bclk      <= 1'b0;
        end else begin
            baud_tick <= wrap && (ocnt == OCNT_LAST);
            if (wrap) begin
                ocnt <= ocnt + OCW'(1);
                if (ocnt == OCNT_HALF || ocnt == OCNT_LAST)
                    bclk <= ~bclk;
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac -- scoreboard bench for baud_gen_frac.
//   Expected tick times are computed arithmetically when a run starts and
//   queued; a negedge monitor pops and compares whenever the DUT pulses.
module tb_baud_gen_frac;

    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;
    localparam int OVS    = 16;
`ifdef BAUD_GEN_FRAC_FRAC_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_div;
    logic [FRAC_W-1:0] cfg_frac;
    logic              ovs_tick;
    logic              baud_tick;
    logic              bclk;

    baud_gen_frac #(
        .DIV_W       (DIV_W),
        .FRAC_W      (FRAC_W),
        .OVS         (OVS),
        .DEFAULT_DIV (651)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_div   (cfg_div),
        .cfg_frac  (cfg_frac),
        .ovs_tick  (ovs_tick),
        .baud_tick (baud_tick),
        .bclk      (bclk)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int     n_checks = 0;
    int     n_fail   = 0;
    bit     mon_en   = 1'b0;
    bit     bclk_prev = 1'b0;
    longint ovs_q[$];
    longint baud_q[$];
    longint bclk_q[$];
    int     cur_div  = 651;
    int     cur_frac = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every DUT pulse/edge must match the head of its queue.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (ovs_tick) begin
                    if (ovs_q.size() == 0) chk("ovs_tick unexpected", cyc, -1);
                    else chk("ovs_tick time", cyc, ovs_q.pop_front());
                end
                if (baud_tick) begin
                    if (baud_q.size() == 0) chk("baud_tick unexpected", cyc, -1);
                    else chk("baud_tick time", cyc, baud_q.pop_front());
                end
                if (bclk != bclk_prev) begin
                    if (bclk_q.size() == 0) chk("bclk toggle unexpected", cyc, -1);
                    else chk("bclk toggle time", cyc, bclk_q.pop_front());
                end
            end
            bclk_prev = bclk;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input longint t);
        while (cyc < t) step();
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cfg_ready && n < 64) begin
            step();
            n++;
        end
        chk("cfg_ready wait", cfg_ready, 1);
    endtask

    task automatic cfg_xfer(input int d, input int f);
        wait_ready();
        cfg_valid = 1'b1;
        cfg_div   = DIV_W'(d);
        cfg_frac  = FRAC_W'(f);
        step();
        cfg_valid = 1'b0;
        cfg_div   = DIV_W'($urandom);
        cfg_frac  = FRAC_W'($urandom);
        chk("cfg_ready low after transfer", cfg_ready, 0);
    endtask

    // Push the expected schedule of n ovs ticks for a run started at c
    // with constant divisor d and fraction f (accumulator starts at 0).
    // Period k is one cycle longer each time the running sum of the
    // fraction crosses a multiple of 2^FRAC_W.
    task automatic push_run(input longint c, input int d, input int f, input int n);
        int deff = (d == 0) ? 1 : d;
        int fe   = FRAC_EN ? f : 0;
        for (int k = 1; k <= n; k++) begin
            longint t = c + longint'(k) * deff + ((longint'(k - 1) * fe) >> FRAC_W);
            ovs_q.push_back(t);
            if (k % OVS == 0)       baud_q.push_back(t);
            if (k % (OVS / 2) == 0) bclk_q.push_back(t);
        end
    endtask

    task automatic drain(input string name);
        repeat (5) step();
        chk({name, " ovs_tick left"},   ovs_q.size(),  0);
        chk({name, " baud_tick left"},  baud_q.size(), 0);
        chk({name, " bclk toggle left"}, bclk_q.size(), 0);
        ovs_q.delete();
        baud_q.delete();
        bclk_q.delete();
    endtask

    // n must be a multiple of OVS so bclk ends low before en drops.
    task automatic run_phase(input bit do_cfg, input int d, input int f, input int n,
                             input string name);
        longint c;
        if (do_cfg) begin
            cfg_xfer(d, f);
            wait_ready();
            cur_div  = d;
            cur_frac = f;
        end
        en = 1'b1;
        c  = cyc;
        push_run(c, cur_div, cur_frac, n);
        wait_until(ovs_q[ovs_q.size() - 1]);
        en = 1'b0;
        drain(name);
    endtask

    initial begin
        longint c;
        rst       = 1'b1;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        cfg_frac  = '0;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("reset ovs_tick", ovs_tick, 0);
        chk("reset baud_tick", baud_tick, 0);
        chk("reset bclk", bclk, 0);
        chk("reset cfg_ready", cfg_ready, 1);
        mon_en = 1'b1;
        step();

        // div 0 behaves as 1; div 4 integer; then 5 cycles idle and restart
        run_phase(1'b1, 0, 0, 32, "div0");
        run_phase(1'b1, 4, 0, 64, "div4");
        run_phase(1'b0, 0, 0, 16, "restart");
        // div 4 + 8/16: 4,4,5,4,5,... (ignored without fractional build)
        run_phase(1'b1, 4, 8, 64, "frac");

        for (int i = 0; i < 4; i++)
            run_phase(1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                      OVS * int'($urandom_range(1, 2)), "random");

        // Divisor change 2 cycles into a div=10 period
        cfg_xfer(10, 0);
        wait_ready();
        en = 1'b1;
        c  = cyc;
        ovs_q.push_back(c + 10);
        for (int j = 1; j <= 15; j++) ovs_q.push_back(c + 10 + 3 * j);
        bclk_q.push_back(c + 10 + 3 * 7);
        bclk_q.push_back(c + 10 + 3 * 15);
        baud_q.push_back(c + 10 + 3 * 15);
        wait_until(c + 1);
        cfg_xfer(3, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("cfg_ready during change", cfg_ready, (cyc >= c + 11) ? 1 : 0);
        end
        wait_until(c + 55);
        en = 1'b0;
        drain("change");
        cur_div = 3;

        // Reset mid-period with a divisor pending
        cfg_xfer(20, 0);
        wait_ready();
        en = 1'b1;
        c  = cyc;
        wait_until(c + 3);
        cfg_xfer(5, 0);
        wait_until(c + 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ovs_q.push_back(c + 8 + 651);
        ovs_q.push_back(c + 8 + 1302);
        @(negedge clk);
        chk("rst ovs_tick", ovs_tick, 0);
        chk("rst baud_tick", baud_tick, 0);
        chk("rst bclk", bclk, 0);
        chk("rst cfg_ready", cfg_ready, 1);
        wait_until(c + 8 + 1302);
        en = 1'b0;
        drain("reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
